// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: captures a multi-hot request vector on e and
// hands out the index of every set bit, one per valid/ready handshake.
module priority_encoder_seq #(
  parameter int CODE_W        = 3,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     e,
  input  logic [(2**CODE_W)-1:0]   d,
  input  logic                     rdy,
  output logic                     v,
  output logic                     a,
  output logic                     b,
  output logic                     c,
  output logic                     last,
  output logic                     none,
  output logic                     busy,
  output logic [CODE_W:0]          count
);

  localparam int N = 2**CODE_W;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [N-1:0]        pend_reg, pend_next;
  logic [CODE_W:0]     count_reg, count_next;
  logic                none_reg, none_next;

  logic [N-1:0]        sel_mask;
  logic [CODE_W-1:0]   sel_idx;
  logic                single;

  // A bit is selected when no higher-priority bit of pend is set.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sel
      logic others;
      if (PRIORITY_HIGH) begin : g_hi
        assign others = |(pend_reg >> (gi + 1));
      end else begin : g_lo
        assign others = |(pend_reg << (N - gi));
      end
      assign sel_mask[gi] = pend_reg[gi] & ~others;
    end
  endgenerate

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_mask[i]) sel_idx = sel_idx | CODE_W'(i);
    end
  end

  assign single = ((pend_reg & (pend_reg - N'(1))) == '0) && (pend_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      count_reg <= '0;
      none_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      count_reg <= count_next;
      none_reg  <= none_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    count_next = count_reg;
    none_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (e) begin
          pend_next  = d;
          count_next = '0;
          if (d != '0) state_next = EMIT;
          else         none_next  = 1'b1;
        end
      end
      EMIT: begin
        // e and d are deliberately ignored here, even on the final handshake.
        if (rdy) begin
          pend_next  = pend_reg & ~sel_mask;
          count_next = count_reg + (CODE_W+1)'(1);
          if (single) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    v     = 1'b0;
    busy  = 1'b0;
    last  = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    c     = 1'b0;
    none  = none_reg;
    count = count_reg;
    if (state_reg == EMIT) begin
      v    = 1'b1;
      busy = 1'b1;
      last = single;
      a    = sel_idx[CODE_W-1];
      b    = sel_idx[1];
      c    = sel_idx[0];
    end
  end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: both priority orders side by side, checked
// against a queue-based model of the emitted code sequence.
module tb_priority_encoder_seq;

  logic       clk = 1'b0;
  logic       reset, e, rdy;
  logic [7:0] d;
  logic       v_h, a_h, b_h, c_h, last_h, none_h, busy_h;
  logic       v_l, a_l, b_l, c_l, last_l, none_l, busy_l;
  logic [3:0] count_h, count_l;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int q_hi[$];
  int q_lo[$];
  int m_cnt  = 0;
  bit m_none = 1'b0;

  typedef struct {
    logic       rst;
    logic       e;
    logic [7:0] d;
    logic       rdy;
    logic       v;
    logic [2:0] code;
    logic       last;
    logic       none;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  priority_encoder_seq #(.CODE_W(3), .PRIORITY_HIGH(1'b1)) dut_h (
    .clk(clk), .reset(reset), .e(e), .d(d), .rdy(rdy),
    .v(v_h), .a(a_h), .b(b_h), .c(c_h), .last(last_h), .none(none_h),
    .busy(busy_h), .count(count_h)
  );

  priority_encoder_seq #(.CODE_W(3), .PRIORITY_HIGH(1'b0)) dut_l (
    .clk(clk), .reset(reset), .e(e), .d(d), .rdy(rdy),
    .v(v_l), .a(a_l), .b(b_l), .c(c_l), .last(last_l), .none(none_l),
    .busy(busy_l), .count(count_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, act, req);
    end
  endtask

  // Model: a capture expands the vector into the ordered list of indices.
  task automatic model_update(input logic r, input logic ee, input logic [7:0] dd, input logic rr);
    if (r) begin
      q_hi.delete(); q_lo.delete(); m_cnt = 0; m_none = 1'b0;
    end else begin
      m_none = 1'b0;
      if (q_hi.size() == 0) begin
        if (ee) begin
          m_cnt = 0;
          for (int i = 7; i >= 0; i--) if (dd[i]) q_hi.push_back(i);
          for (int i = 0; i < 8; i++)  if (dd[i]) q_lo.push_back(i);
          if (dd == 8'h00) m_none = 1'b1;
        end
      end else if (rr) begin
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
        m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = (q_hi.size() > 0);
    chk("v_h", v_h, ev);
    chk("v_l", v_l, ev);
    chk("busy_h", busy_h, ev);
    chk("busy_l", busy_l, ev);
    chk("code_h", {a_h, b_h, c_h}, ev ? q_hi[0] : 0);
    chk("code_l", {a_l, b_l, c_l}, ev ? q_lo[0] : 0);
    chk("last_h", last_h, ev && q_hi.size() == 1);
    chk("last_l", last_l, ev && q_lo.size() == 1);
    chk("none_h", none_h, m_none);
    chk("none_l", none_l, m_none);
    chk("count_h", count_h, m_cnt);
    chk("count_l", count_l, m_cnt);
  endtask

  task automatic step(input logic r, input logic ee, input logic [7:0] dd, input logic rr);
    reset = r; e = ee; d = dd; rdy = rr;
    @(posedge clk);
    model_update(r, ee, dd, rr);
    @(negedge clk);
    cyc++;
    check_all();
    $display("cyc=%0d rst=%0b e=%0b d=%02h rdy=%0b | v=%0b code_h=%0d code_l=%0d last=%0b/%0b none=%0b cnt=%0d",
             cyc, r, ee, dd, rr, v_h, {a_h, b_h, c_h}, {a_l, b_l, c_l}, last_h, last_l, none_h, count_h);
  endtask

  initial begin
    // rst, e, d, rdy, v, code, last, none, busy, cnt
    tbl[0] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 4'd1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 4'd2};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd3};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0};

    reset = 1'b1; e = 1'b0; d = 8'h00; rdy = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("reset_v", v_h, 1'b0);
    chk("reset_count", count_h, 4'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Directed table: burst 7,5,2 then an empty capture.
    for (int k = 0; k < 6; k++) begin
      step(tbl[k].rst, tbl[k].e, tbl[k].d, tbl[k].rdy);
      chk("tbl_v", v_h, tbl[k].v);
      chk("tbl_code", {a_h, b_h, c_h}, tbl[k].code);
      chk("tbl_last", last_h, tbl[k].last);
      chk("tbl_none", none_h, tbl[k].none);
      chk("tbl_busy", busy_h, tbl[k].busy);
      chk("tbl_cnt", count_h, tbl[k].cnt);
    end

    // Back-pressure on 8'h81.
    step(1'b0, 1'b1, 8'h81, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("bp_code", {a_h, b_h, c_h}, 3'd7);
      chk("bp_v", v_h, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bp_code0", {a_h, b_h, c_h}, 3'd0);
    chk("bp_last", last_h, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("bp_count", count_h, 4'd2);

    // e during EMIT is ignored, including on the final handshake.
    step(1'b0, 1'b1, 8'h18, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("ign_code3", {a_h, b_h, c_h}, 3'd3);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("ign_idle", v_h, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    chk("ign_newcap", {a_h, b_h, c_h}, 3'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-burst drops the remaining codes.
    step(1'b0, 1'b1, 8'hF0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("rst_mid_busy", busy_h, 1'b0);
    chk("rst_mid_cnt", count_h, 4'd0);
    step(1'b0, 1'b1, 8'h30, 1'b1);
    chk("rst_fresh", {a_h, b_h, c_h}, 3'd5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // All-ones vector: low-priority instance walks 0..7, count reaches 8.
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("ff_code_l", {a_l, b_l, c_l}, k);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("ff_count8", count_l, 4'd8);
    chk("ff_done", v_l, 1'b0);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      logic       rr, ee, rd;
      logic [7:0] dd;
      rr = ($urandom_range(0, 49) == 0);
      ee = ($urandom_range(0, 2) != 0);
      dd = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      step(rr, ee, dd, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
